// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the convolution control path (loop sequencer, operand fetch).
package conv_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_t;

  // Width of an index counter covering 0..n-1; never zero, even for n == 1.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : unsigned'($clog2(n));
  endfunction

  localparam int unsigned CmdXWidth   = 6;
  localparam int unsigned CmdYWidth   = 6;
  localparam int unsigned CmdOchWidth = 5;
  localparam int unsigned CmdIchWidth = 2;
  localparam int unsigned CmdKyWidth  = 2;

  typedef struct packed {
    logic [CmdXWidth-1:0]   x;
    logic [CmdYWidth-1:0]   y;
    logic [CmdOchWidth-1:0] och;
    logic [CmdIchWidth-1:0] ich;
    logic [CmdKyWidth-1:0]  ky;
    logic                   first;
    logic                   last;
  } cmd_beat_t;

endpackage

// File: rtl/conv_loop_sequencer_loop_counter.sv
// Wrapping index counter 0..MAX with increment enable and wrap carry-out for odometer chains.
module loop_counter
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned MAX   = 1,
  parameter int unsigned WIDTH = clog2_min1(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    wrap    = inc && (count_q == MaxVal);
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/conv_loop_sequencer.sv
// Loop-nest command sequencer for the convolution datapath (y > x > och > ich > ky).
// Optional CONV_LOOP_SEQUENCER_PERF_EN adds stall/busy performance counters.
module conv_loop_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned FEATURE_MAP_WIDTH  = 64,
  parameter int unsigned FEATURE_MAP_HEIGHT = 64,
  parameter int unsigned INPUT_NB_CHANNELS  = 4,
  parameter int unsigned OUTPUT_NB_CHANNELS = 32,
  parameter int unsigned KERNEL_SIZE        = 3,
  parameter int unsigned PIPE_LATENCY       = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  output logic                                         running,
  output logic                                         done,
  output logic                                         cmd_valid,
  input  logic                                         cmd_ready,
  output logic [clog2_min1(FEATURE_MAP_WIDTH)-1:0]     cmd_x,
  output logic [clog2_min1(FEATURE_MAP_HEIGHT)-1:0]    cmd_y,
  output logic [clog2_min1(OUTPUT_NB_CHANNELS)-1:0]    cmd_och,
  output logic [clog2_min1(INPUT_NB_CHANNELS)-1:0]     cmd_ich,
  output logic [clog2_min1(KERNEL_SIZE)-1:0]           cmd_ky,
  output logic                                         cmd_first,
  output logic                                         cmd_last
`ifdef CONV_LOOP_SEQUENCER_PERF_EN
  ,
  output logic [31:0]                                  stall_cycles,
  output logic [31:0]                                  busy_cycles
`endif
);

  localparam int unsigned DrainWidth = clog2_min1(PIPE_LATENCY + 1);

  seq_state_t            state_d, state_q;
  logic [DrainWidth-1:0] drain_d, drain_q;
  logic                  done_d, done_q;
  logic                  accept, xfer;
  logic                  ky_wrap, ich_wrap, och_wrap, x_wrap, y_wrap;

  // A start coinciding with done is dropped so a layer always sees a quiet idle cycle.
  assign accept = (state_q == IDLE) && start && !done_q;
  assign xfer   = cmd_valid && cmd_ready;

  loop_counter #(.MAX(KERNEL_SIZE - 1), .WIDTH(clog2_min1(KERNEL_SIZE))) u_ky (
    .clk(clk), .rst(rst), .clr(accept), .inc(xfer), .count(cmd_ky), .wrap(ky_wrap)
  );
  loop_counter #(.MAX(INPUT_NB_CHANNELS - 1), .WIDTH(clog2_min1(INPUT_NB_CHANNELS))) u_ich (
    .clk(clk), .rst(rst), .clr(accept), .inc(ky_wrap), .count(cmd_ich), .wrap(ich_wrap)
  );
  loop_counter #(.MAX(OUTPUT_NB_CHANNELS - 1), .WIDTH(clog2_min1(OUTPUT_NB_CHANNELS))) u_och (
    .clk(clk), .rst(rst), .clr(accept), .inc(ich_wrap), .count(cmd_och), .wrap(och_wrap)
  );
  loop_counter #(.MAX(FEATURE_MAP_WIDTH - 1), .WIDTH(clog2_min1(FEATURE_MAP_WIDTH))) u_x (
    .clk(clk), .rst(rst), .clr(accept), .inc(och_wrap), .count(cmd_x), .wrap(x_wrap)
  );
  loop_counter #(.MAX(FEATURE_MAP_HEIGHT - 1), .WIDTH(clog2_min1(FEATURE_MAP_HEIGHT))) u_y (
    .clk(clk), .rst(rst), .clr(accept), .inc(x_wrap), .count(cmd_y), .wrap(y_wrap)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        // y_wrap only fires on the transfer of the all-max beat.
        if (y_wrap) begin
          state_d = DRAIN;
          drain_d = DrainWidth'(PIPE_LATENCY);
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  assign running   = (state_q != IDLE);
  assign done      = done_q;
  assign cmd_valid = (state_q == RUN);
  assign cmd_first = cmd_valid && (cmd_ich == '0) && (cmd_ky == '0);
  assign cmd_last  = cmd_valid && (cmd_ich == (clog2_min1(INPUT_NB_CHANNELS))'(INPUT_NB_CHANNELS - 1))
                     && (cmd_ky == (clog2_min1(KERNEL_SIZE))'(KERNEL_SIZE - 1));

`ifdef CONV_LOOP_SEQUENCER_PERF_EN
  logic [31:0] stall_q, busy_q;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stall_q <= '0;
      busy_q  <= '0;
    end else begin
      if (cmd_valid && !cmd_ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (running && (busy_q != '1)) busy_q <= busy_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign busy_cycles  = busy_q;
`endif

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Scoreboard bench for conv_loop_sequencer: small layer, backpressure, restart, reset, degenerate.
module tb_conv_loop_sequencer;

  localparam int W = 2, H = 2, ICH = 2, OCH = 2, K = 3, PL = 4;
  localparam int NBEATS = W * H * ICH * OCH * K;

  logic       clk = 1'b0;
  logic       rst, start, cmd_ready, start_b, ready_b;
  logic       running, done, cmd_valid, cmd_first, cmd_last;
  logic [0:0] cmd_x, cmd_y, cmd_och, cmd_ich;
  logic [1:0] cmd_ky;
  logic       b_running, b_done, b_valid, b_first, b_last;
  logic [0:0] b_x, b_y, b_ich, b_ky;
  logic [1:0] b_och;
`ifdef CONV_LOOP_SEQUENCER_PERF_EN
  logic [31:0] stall_cycles, busy_cycles, b_stall, b_busy;
`endif

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0, beat_cnt, done_cnt, drain_cnt, first_xfer, last_xfer, done_cyc;
  int b_beats = 0, b_done_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_loop_sequencer #(
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .INPUT_NB_CHANNELS(ICH),
    .OUTPUT_NB_CHANNELS(OCH), .KERNEL_SIZE(K), .PIPE_LATENCY(PL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .running(running), .done(done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_och(cmd_och), .cmd_ich(cmd_ich), .cmd_ky(cmd_ky), .cmd_first(cmd_first),
    .cmd_last(cmd_last)
`ifdef CONV_LOOP_SEQUENCER_PERF_EN
    , .stall_cycles(stall_cycles), .busy_cycles(busy_cycles)
`endif
  );

  conv_loop_sequencer #(
    .FEATURE_MAP_WIDTH(1), .FEATURE_MAP_HEIGHT(1), .INPUT_NB_CHANNELS(1),
    .OUTPUT_NB_CHANNELS(3), .KERNEL_SIZE(1), .PIPE_LATENCY(PL)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .running(b_running), .done(b_done),
    .cmd_valid(b_valid), .cmd_ready(ready_b), .cmd_x(b_x), .cmd_y(b_y),
    .cmd_och(b_och), .cmd_ich(b_ich), .cmd_ky(b_ky), .cmd_first(b_first),
    .cmd_last(b_last)
`ifdef CONV_LOOP_SEQUENCER_PERF_EN
    , .stall_cycles(b_stall), .busy_cycles(b_busy)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] pack(input int x, y, och, ich, ky);
    logic f, l;
    f = (ich == 0) && (ky == 0);
    l = (ich == ICH - 1) && (ky == K - 1);
    return {x[0], y[0], och[0], ich[0], ky[1:0], f, l};
  endfunction

  // Reference loop nest: ky innermost, y outermost.
  task automatic push_layer();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int o = 0; o < OCH; o++)
          for (int i = 0; i < ICH; i++)
            for (int k = 0; k < K; k++) exp_q.push_back(pack(x, y, o, i, k));
  endtask

  task automatic clear_stats();
    beat_cnt = 0; done_cnt = 0; drain_cnt = 0; first_xfer = 0; last_xfer = 0; done_cyc = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input bit poke);
    int n = 0;
    bit p3 = 0, p20 = 0, pd = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (rnd) cmd_ready = 1'($urandom_range(0, 1));
      if (poke) begin
        if (beat_cnt == 3 && !p3) begin start = 1'b1; p3 = 1; end
        if (beat_cnt == 20 && !p20) begin start = 1'b1; p20 = 1; end
        if (running && !cmd_valid && !pd) begin start = 1'b1; pd = 1; end
      end
      if (done) start = 1'b1;  // must be ignored: start coincides with done
    end
    start = 1'b0;
    cmd_ready = 1'b1;
    if (done_cnt == 0) check("done_timeout", done_cnt, 1);
  endtask

  task automatic layer_checks(input string tag);
    check({tag, "_beats"}, beat_cnt, NBEATS);
    check({tag, "_sb_left"}, exp_q.size(), 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_drain_len"}, drain_cnt, PL + 1);
    check({tag, "_done_delay"}, done_cyc - last_xfer, PL + 2);
    check({tag, "_idle_running"}, running, 0);
    check({tag, "_idle_valid"}, cmd_valid, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) begin
        if (exp_q.size() == 0) check("sb_extra", exp_q.size(), 1);
        else if (cmd_ready) begin
          check("beat", {cmd_x, cmd_y, cmd_och, cmd_ich, cmd_ky, cmd_first, cmd_last},
                exp_q.pop_front());
          if (beat_cnt == 0) first_xfer = cyc;
          last_xfer = cyc;
          beat_cnt++;
        end else begin
          check("stall_hold", {cmd_x, cmd_y, cmd_och, cmd_ich, cmd_ky, cmd_first, cmd_last},
                exp_q[0]);
        end
      end
      if (running && !cmd_valid) drain_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (b_valid) begin
        check("b_first", b_first, 1);
        check("b_last", b_last, 1);
        check("b_och", b_och, b_beats);
        b_beats++;
      end
      if (b_done) b_done_cnt++;
    end
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; cmd_ready = 1'b1; start_b = 1'b0; ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_idx", {cmd_x, cmd_y, cmd_och, cmd_ich, cmd_ky}, 0);
    check("rst_flags", {cmd_first, cmd_last}, 0);
    check("rst_b_running", b_running, 0);
    rst = 1'b0;

    // Layer with ready tied high, start at cycle 10.
    while (cyc < 10) @(posedge clk);
    #1;
    clear_stats();
    push_layer();
    pulse_start();
    check("t1_running", running, 1);
    wait_done(300, 0, 0);
    layer_checks("t1");
    check("t1_back_to_back", last_xfer - first_xfer, NBEATS - 1);

    // Random backpressure plus ignored start pulses at beats 3, 20 and in drain.
    clear_stats();
    push_layer();
    pulse_start();
    wait_done(3000, 1, 1);
    layer_checks("t2");

    // Reset in the middle of a layer abandons it silently.
    clear_stats();
    push_layer();
    pulse_start();
    n = 0;
    while (beat_cnt < 17 && n < 200) begin @(posedge clk); #1; n++; end
    check("t3_reached_17", beat_cnt, 17);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t3_rst_running", running, 0);
    check("t3_rst_valid", cmd_valid, 0);
    check("t3_rst_idx", {cmd_x, cmd_y, cmd_och, cmd_ich, cmd_ky}, 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("t3_no_done", done_cnt, 0);
    clear_stats();
    push_layer();
    pulse_start();
    wait_done(300, 0, 0);
    layer_checks("t3_relayer");

    // Degenerate instance: every beat first and last, och 0..2.
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0;
    while (b_done_cnt == 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("b_beats", b_beats, 3);
    check("b_done_cnt", b_done_cnt, 1);

`ifdef CONV_LOOP_SEQUENCER_PERF_EN
    clear_stats();
    push_layer();
    pulse_start();
    cmd_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    wait_done(300, 0, 0);
    check("perf_stall", stall_cycles, 10);
    check("perf_busy", busy_cycles, NBEATS + 10 + PL + 1);
    push_layer();
    pulse_start();
    check("perf_stall_clr", stall_cycles, 0);
    check("perf_busy_clr", busy_cycles, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
